// File: rtl/mem_access_if.sv
// mem_access_if: execute -> memory-stage -> writeback handshake plus the data-bus
// request/response. slave = the memory stage, master = the surrounding pipeline/bus.
interface mem_access_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_memop;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic [RD_W-1:0]     in_rd;
  logic                dreq_valid;
  logic [ADDR_W-1:0]   dreq_addr;
  logic [2:0]          dreq_size;
  logic [DATA_W/8-1:0] dreq_strobe;
  logic [DATA_W-1:0]   dreq_data;
  logic                dresp_data_ok;
  logic [DATA_W-1:0]   dresp_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_result;
  logic [RD_W-1:0]     out_rd;
  logic                out_misalign;

  modport slave (
    input  flush, in_valid, in_memop, in_addr, in_wdata, in_rd,
           dresp_data_ok, dresp_data, out_ready,
    output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           out_valid, out_result, out_rd, out_misalign
  );

  modport master (
    output flush, in_valid, in_memop, in_addr, in_wdata, in_rd,
           dresp_data_ok, dresp_data, out_ready,
    input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           out_valid, out_result, out_rd, out_misalign
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: RV64 memory stage (IDLE/REQ/DONE) issuing one bus request per load/store
// and aligning load data. Define MEM_MISALIGN_CHECK_EN to trap misaligned accesses.
module mem_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1,  OP_LH  = 4'd2,  OP_LW  = 4'd3, OP_LD = 4'd4,
                         OP_LBU = 4'd5,  OP_LHU = 4'd6,  OP_LWU = 4'd7, OP_SB = 4'd8,
                         OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SD  = 4'd11;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W/8-1:0] strobe_q, strobe_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          op_q, op_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                misalign_q, misalign_d;
  logic                flushed_q, flushed_d;

  logic                is_load, is_store, accept;
  logic [1:0]          in_size;
  logic [7:0]          lane_mask;
  logic [DATA_W-1:0]   rdata_sh, load_value;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    in_size   = 2'd0;
    lane_mask = 8'h00;
    case (bus.in_memop)
      OP_LB, OP_LBU: begin is_load  = 1'b1; in_size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; in_size = 2'd1; end
      OP_LW, OP_LWU: begin is_load  = 1'b1; in_size = 2'd2; end
      OP_LD:         begin is_load  = 1'b1; in_size = 2'd3; end
      OP_SB:         begin is_store = 1'b1; in_size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; in_size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; in_size = 2'd2; end
      OP_SD:         begin is_store = 1'b1; in_size = 2'd3; end
      default: ;
    endcase
    case (in_size)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.in_addr[0];
      2'd2:    misaligned = |bus.in_addr[1:0];
      default: misaligned = |bus.in_addr[2:0];
    endcase
  end
`endif

  // Response data is a full aligned doubleword; shift the addressed byte to lane 0.
  always_comb begin
    rdata_sh = bus.dresp_data >> {addr_q[2:0], 3'b000};
    case (op_q)
      OP_LB:   load_value = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      OP_LH:   load_value = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      OP_LW:   load_value = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      OP_LD:   load_value = rdata_sh;
      OP_LBU:  load_value = {56'd0, rdata_sh[7:0]};
      OP_LHU:  load_value = {48'd0, rdata_sh[15:0]};
      OP_LWU:  load_value = {32'd0, rdata_sh[31:0]};
      default: load_value = '0;
    endcase
  end

  assign bus.in_ready = ((state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready)) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    rd_d       = rd_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    flushed_d  = flushed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (accept) begin
          op_d       = bus.in_memop;
          rd_d       = bus.in_rd;
          addr_d     = bus.in_addr;
          size_d     = in_size;
          misalign_d = 1'b0;
          flushed_d  = 1'b0;
          strobe_d   = is_store ? (lane_mask << bus.in_addr[2:0]) : '0;
          wdata_d    = is_store ? (bus.in_wdata << {bus.in_addr[2:0], 3'b000}) : '0;
          if (!is_load && !is_store) begin
            state_d  = S_DONE;
            result_d = bus.in_addr;
          end else begin
            state_d  = S_REQ;
            result_d = '0;
            if (is_store) rd_d = '0;
`ifdef MEM_MISALIGN_CHECK_EN
            if (misaligned) begin
              state_d    = S_DONE;
              misalign_d = 1'b1;
              result_d   = bus.in_addr;
              rd_d       = '0;
            end
`endif
          end
        end else if (state_q == S_DONE && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // A flush cannot abort the bus transaction; remember it and drop the result.
        if (bus.flush) flushed_d = 1'b1;
        if (bus.dresp_data_ok) begin
          state_d   = (flushed_q || bus.flush) ? S_IDLE : S_DONE;
          result_d  = load_value;
          flushed_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
      flushed_q  <= flushed_d;
    end
  end

  assign bus.dreq_valid   = (state_q == S_REQ);
  assign bus.dreq_addr    = addr_q;
  assign bus.dreq_size    = {1'b0, size_q};
  assign bus.dreq_strobe  = strobe_q;
  assign bus.dreq_data    = wdata_q;
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.out_result   = result_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed-vector bench for the mem_access memory stage; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mem_access;
  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LD = 4'd4, OP_LBU = 4'd5, OP_LHU = 4'd6, OP_LWU = 4'd7,
                         OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10, OP_SD = 4'd11;

  mem_access_if bus_if ();

  mem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus_if.flush         = 1'b0;
    bus_if.in_valid      = 1'b0;
    bus_if.in_memop      = OP_NONE;
    bus_if.in_addr       = '0;
    bus_if.in_wdata      = '0;
    bus_if.in_rd         = '0;
    bus_if.dresp_data_ok = 1'b0;
    bus_if.dresp_data    = '0;
    bus_if.out_ready     = 1'b1;
  endtask

  task automatic present(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [4:0] rd);
    bus_if.in_valid = 1'b1;
    bus_if.in_memop = op;
    bus_if.in_addr  = addr;
    bus_if.in_wdata = wdata;
    bus_if.in_rd    = rd;
  endtask

  // Full load/store transaction with a one-cycle bus wait; returns what the DUT showed.
  task automatic do_mem(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        output logic [7:0] strobe, output logic [63:0] wd, output logic [2:0] size,
                        output logic [63:0] result, output logic [4:0] rd_o, output logic valid_o);
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    present(op, addr, wdata, rd);
    @(negedge clk);
    bus_if.in_valid      = 1'b0;
    strobe               = bus_if.dreq_strobe;
    wd                   = bus_if.dreq_data;
    size                 = bus_if.dreq_size;
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = rdata;
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    result  = bus_if.out_result;
    rd_o    = bus_if.out_rd;
    valid_o = bus_if.out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    tests_run++; if (bus_if.dreq_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dreq_valid: got %b want 0", bus_if.dreq_valid); end
    tests_run++; if (bus_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    tests_run++; if (bus_if.out_result !== 64'd0) begin tests_failed++; $display("FAIL reset_out_result: got %h want 0", bus_if.out_result); end
    tests_run++; if (bus_if.dreq_strobe !== 8'd0) begin tests_failed++; $display("FAIL reset_strobe: got %h want 0", bus_if.dreq_strobe); end
    tests_run++; if (bus_if.out_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b want 0", bus_if.out_misalign); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
  endtask

  task automatic test_none();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    present(OP_NONE, 64'h1234, 64'd0, 5'd5);
    #1;
    tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL none_in_ready: got %b want 1", bus_if.in_ready); end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    tests_run++; if (bus_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL none_out_valid: got %b want 1", bus_if.out_valid); end
    tests_run++; if (bus_if.dreq_valid !== 1'b0) begin tests_failed++; $display("FAIL none_dreq_valid: got %b want 0", bus_if.dreq_valid); end
    tests_run++; if (bus_if.out_result !== 64'h1234) begin tests_failed++; $display("FAIL none_result: got %h want 1234", bus_if.out_result); end
    tests_run++; if (bus_if.out_rd !== 5'd5) begin tests_failed++; $display("FAIL none_rd: got %0d want 5", bus_if.out_rd); end
    @(negedge clk);
    tests_run++; if (bus_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL none_retire: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_load_lb();
    @(negedge clk);
    present(OP_LB, 64'h1003, 64'd0, 5'd7);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    tests_run++; if (bus_if.dreq_valid !== 1'b1) begin tests_failed++; $display("FAIL lb_dreq_valid: got %b want 1", bus_if.dreq_valid); end
    tests_run++; if (bus_if.dreq_addr !== 64'h1003) begin tests_failed++; $display("FAIL lb_dreq_addr: got %h want 1003", bus_if.dreq_addr); end
    tests_run++; if (bus_if.dreq_size !== 3'd0) begin tests_failed++; $display("FAIL lb_dreq_size: got %0d want 0", bus_if.dreq_size); end
    tests_run++; if (bus_if.dreq_strobe !== 8'h00) begin tests_failed++; $display("FAIL lb_strobe: got %h want 00", bus_if.dreq_strobe); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests_run++; if (bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL lb_in_ready_req%0d: got %b want 0", i, bus_if.in_ready); end
      tests_run++; if (bus_if.dreq_addr !== 64'h1003) begin tests_failed++; $display("FAIL lb_addr_hold%0d: got %h want 1003", i, bus_if.dreq_addr); end
    end
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'h00000000_80000000;
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    tests_run++; if (bus_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL lb_out_valid: got %b want 1", bus_if.out_valid); end
    tests_run++; if (bus_if.out_result !== 64'hFFFFFFFF_FFFFFF80) begin tests_failed++; $display("FAIL lb_result: got %h want ffffffffffffff80", bus_if.out_result); end
    tests_run++; if (bus_if.out_rd !== 5'd7) begin tests_failed++; $display("FAIL lb_rd: got %0d want 7", bus_if.out_rd); end
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [7] = '{OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    logic [63:0] adrs [7] = '{64'h101, 64'h102, 64'h104, 64'h100, 64'h105, 64'h106, 64'h100};
    logic [63:0] exps [7] = '{64'hFFFFFFFF_FFFFFFEE, 64'hFFFFFFFF_FFFFCCDD, 64'hFFFFFFFF_8899AABB,
                              64'h8899AABB_CCDDEEFF, 64'h00000000_000000AA, 64'h00000000_00008899,
                              64'h00000000_CCDDEEFF};
    logic [7:0] strobe; logic [63:0] wd, result; logic [2:0] size; logic [4:0] rd_o; logic valid_o;
    for (int i = 0; i < 7; i++) begin
      do_mem(ops[i], adrs[i], 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h8899AABB_CCDDEEFF,
             strobe, wd, size, result, rd_o, valid_o);
      tests_run++; if (result !== exps[i] || valid_o !== 1'b1) begin tests_failed++; $display("FAIL load%0d_result: got %h valid %b want %h", i, result, valid_o, exps[i]); end
      tests_run++; if (strobe !== 8'h00 || rd_o !== 5'd10) begin tests_failed++; $display("FAIL load%0d_strobe_rd: got %h/%0d want 00/10", i, strobe, rd_o); end
    end
  endtask

  task automatic test_stores();
    logic [3:0]  ops  [4] = '{OP_SH, OP_SB, OP_SW, OP_SD};
    logic [63:0] adrs [4] = '{64'h2006, 64'h203, 64'h204, 64'h200};
    logic [63:0] wds  [4] = '{64'h0000_0000_0000_BEEF, 64'h11223344_55667788, 64'h11223344_55667788, 64'h11223344_55667788};
    logic [7:0]  sexp [4] = '{8'hC0, 8'h08, 8'hF0, 8'hFF};
    logic [63:0] dexp [4] = '{64'hBEEF0000_00000000, 64'h44556677_88000000, 64'h55667788_00000000, 64'h11223344_55667788};
    logic [2:0]  zexp [4] = '{3'd1, 3'd0, 3'd2, 3'd3};
    logic [7:0] strobe; logic [63:0] wd, result; logic [2:0] size; logic [4:0] rd_o; logic valid_o;
    for (int i = 0; i < 4; i++) begin
      do_mem(ops[i], adrs[i], wds[i], 5'd9, 64'hDEADBEEF_CAFEF00D, strobe, wd, size, result, rd_o, valid_o);
      tests_run++; if (strobe !== sexp[i] || size !== zexp[i]) begin tests_failed++; $display("FAIL store%0d_strobe_size: got %h/%0d want %h/%0d", i, strobe, size, sexp[i], zexp[i]); end
      tests_run++; if (wd !== dexp[i]) begin tests_failed++; $display("FAIL store%0d_data: got %h want %h", i, wd, dexp[i]); end
      tests_run++; if (result !== 64'd0 || rd_o !== 5'd0 || valid_o !== 1'b1) begin tests_failed++; $display("FAIL store%0d_out: got %h rd %0d valid %b want 0 rd 0 valid 1", i, result, rd_o, valid_o); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    present(OP_LWU, 64'h3004, 64'd0, 5'd3);
    @(negedge clk);
    present(OP_NONE, 64'h55AA, 64'd0, 5'd4);
    #1;
    tests_run++; if (bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_in_ready_req: got %b want 0", bus_if.in_ready); end
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'h89ABCDEF_01234567;
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests_run++; if (bus_if.out_valid !== 1'b1 || bus_if.out_result !== 64'h00000000_89ABCDEF) begin tests_failed++; $display("FAIL b2b_hold%0d: got valid %b result %h want 1 0000000089abcdef", i, bus_if.out_valid, bus_if.out_result); end
      tests_run++; if (bus_if.in_ready !== 1'b0 || bus_if.out_rd !== 5'd3) begin tests_failed++; $display("FAIL b2b_hold%0d_ready_rd: got %b/%0d want 0/3", i, bus_if.in_ready, bus_if.out_rd); end
    end
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    #1;
    tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready_done: got %b want 1", bus_if.in_ready); end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    tests_run++; if (bus_if.out_valid !== 1'b1 || bus_if.out_result !== 64'h55AA || bus_if.out_rd !== 5'd4) begin tests_failed++; $display("FAIL b2b_second: got valid %b result %h rd %0d want 1 55aa 4", bus_if.out_valid, bus_if.out_result, bus_if.out_rd); end
    @(negedge clk);
    tests_run++; if (bus_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    present(OP_LD, 64'h4008, 64'd0, 5'd6);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    bus_if.flush = 1'b1;
    tests_run++; if (bus_if.dreq_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_req_c2: got %b want 1", bus_if.dreq_valid); end
    @(negedge clk);
    bus_if.flush = 1'b0;
    tests_run++; if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_addr !== 64'h4008) begin tests_failed++; $display("FAIL flush_req_held: got %b addr %h want 1 4008", bus_if.dreq_valid, bus_if.dreq_addr); end
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    #1;
    tests_run++; if (bus_if.out_valid !== 1'b0 || bus_if.dreq_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard: got valid %b dreq %b want 0 0", bus_if.out_valid, bus_if.dreq_valid); end
    tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", bus_if.in_ready); end
    // Flush while a result waits in DONE: no accept, result dropped.
    bus_if.out_ready = 1'b0;
    present(OP_NONE, 64'h77, 64'd0, 5'd2);
    @(negedge clk);
    present(OP_NONE, 64'h88, 64'd0, 5'd1);
    bus_if.flush = 1'b1;
    #1;
    tests_run++; if (bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_done_ready: got %b want 0", bus_if.in_ready); end
    @(negedge clk);
    bus_if.flush     = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tests_run++; if (bus_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_done_drop: got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    present(OP_LD, 64'h5000, 64'd0, 5'd11);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    reset           = 1'b1;
    @(negedge clk);
    reset                = 1'b0;
    bus_if.dresp_data_ok = 1'b1;
    tests_run++; if (bus_if.dreq_valid !== 1'b0 || bus_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_drop: got dreq %b valid %b want 0 0", bus_if.dreq_valid, bus_if.out_valid); end
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    tests_run++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_stray_ok: got valid %b ready %b want 0 1", bus_if.out_valid, bus_if.in_ready); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    present(OP_LW, 64'h1002, 64'd0, 5'd8);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    tests_run++; if (bus_if.dreq_valid !== 1'b0 || bus_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL mis_no_req: got dreq %b valid %b want 0 1", bus_if.dreq_valid, bus_if.out_valid); end
    tests_run++; if (bus_if.out_misalign !== 1'b1 || bus_if.out_result !== 64'h1002 || bus_if.out_rd !== 5'd0) begin tests_failed++; $display("FAIL mis_flag: got %b %h rd %0d want 1 1002 0", bus_if.out_misalign, bus_if.out_result, bus_if.out_rd); end
`else
    tests_run++; if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_size !== 3'd2) begin tests_failed++; $display("FAIL mis_req: got dreq %b size %0d want 1 2", bus_if.dreq_valid, bus_if.dreq_size); end
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'hFFFF8000_00001234;
    @(negedge clk);
    bus_if.dresp_data_ok = 1'b0;
    tests_run++; if (bus_if.out_misalign !== 1'b0 || bus_if.out_result !== 64'hFFFFFFFF_80000000) begin tests_failed++; $display("FAIL mis_off: got %b %h want 0 ffffffff80000000", bus_if.out_misalign, bus_if.out_result); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_none();
    test_load_lb();
    test_loads();
    test_stores();
    test_back_to_back();
    test_flush();
    test_reset_mid_req();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
